seven_segment_counter_mux: RTL

- Parametrised multi-digit decimal counter driving a time-multiplexed common-cathode seven-segment display.
- A prescaler generates a count tick. On each tick a cascaded BCD counter steps up or down.
- A scan engine cycles one-hot digit enables and presents the matching segment pattern.
- Sits between the board I/O (switches, display) and the clock; replaces the single-digit seconds display.

---
 rtl/seg7_pkg.sv | 39 +++
 rtl/bcd_digit.sv | 32 +++
 rtl/seven_segment_counter_mux.sv | 123 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared BCD type, seven-segment glyph constants (bit0=a .. bit6=g)
// and the decode/clamp helpers used by the counter display.
package seg7_pkg;

   typedef logic [3:0] bcd_t;

   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;

   // Non-decimal codes show "0" so a corrupted digit never lights a random pattern.
   function automatic logic [6:0] seg7_decode(input bcd_t d);
      case (d)
         4'd0:    seg7_decode = SEG_0;
         4'd1:    seg7_decode = SEG_1;
         4'd2:    seg7_decode = SEG_2;
         4'd3:    seg7_decode = SEG_3;
         4'd4:    seg7_decode = SEG_4;
         4'd5:    seg7_decode = SEG_5;
         4'd6:    seg7_decode = SEG_6;
         4'd7:    seg7_decode = SEG_7;
         4'd8:    seg7_decode = SEG_8;
         4'd9:    seg7_decode = SEG_9;
         default: seg7_decode = SEG_0;
      endcase
   endfunction

   function automatic bcd_t bcd_clamp(input bcd_t d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the cascaded up/down BCD counter; carry_out is the
// combinational step request for the next more-significant digit.
module bcd_digit
   import seg7_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic step,
   input  logic up_dn,
   input  logic load,
   input  bcd_t load_val,
   output bcd_t value,
   output logic carry_out
);

   bcd_t r_value;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_value <= 4'd0;
      end else if (load) begin
         r_value <= bcd_clamp(load_val);
      end else if (step) begin
         if (up_dn) r_value <= (r_value == 4'd9) ? 4'd0 : r_value + 4'd1;
         else       r_value <= (r_value == 4'd0) ? 4'd9 : r_value - 4'd1;
      end
   end

   assign value     = r_value;
   assign carry_out = step & (up_dn ? (r_value == 4'd9) : (r_value == 4'd0));

endmodule

// File: rtl/seven_segment_counter_mux.sv
// Multi-digit BCD up/down counter with prescaled tick and multiplexed
// common-cathode display. Optional macro: LEADING_ZERO_BLANK_EN.
module seven_segment_counter_mux
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int CNT_WIDTH  = 24,
   parameter int MAX_COUNT  = 10_000_000,
   parameter int SCAN_DIV   = 10_000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic                    up_dn,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_val,
   input  logic [7:0]              cmp_in,
   output logic [6:0]              segments,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic [4*NUM_DIGITS-1:0] count_bcd,
   output logic                    tick,
   output logic                    wrap
);

   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [CNT_WIDTH-1:0]  r_presc;
   logic [CNT_WIDTH-1:0]  w_cmp;
   logic                  r_tick;
   logic                  r_wrap;
   logic [SCAN_W-1:0]     r_scan_cnt;
   logic [IDX_W-1:0]      r_scan_idx;
   logic [NUM_DIGITS-1:0] r_digit_sel;
   logic [6:0]            r_segments;
   bcd_t                  w_digit [NUM_DIGITS];
   logic                  w_blank;

   assign w_cmp = (cmp_in == 8'd0) ? CNT_WIDTH'(MAX_COUNT) : CNT_WIDTH'({cmp_in, 10'b0});

   // ">=" lets a compare lowered below the running count restart on the next cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_presc <= '0;
         r_tick  <= 1'b0;
      end else if (en) begin
         if (r_presc >= w_cmp) begin
            r_presc <= '0;
            r_tick  <= 1'b1;
         end else begin
            r_presc <= r_presc + 1'b1;
            r_tick  <= 1'b0;
         end
      end else begin
         r_tick <= 1'b0;
      end
   end

   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
      logic w_step;
      logic w_carry;
      if (gi == 0) begin : g_lsd
         assign w_step = r_tick & en;
      end else begin : g_chain
         assign w_step = g_dig[gi-1].w_carry;
      end
      bcd_digit u_digit (
         .clk       (clk),
         .reset     (reset),
         .step      (w_step),
         .up_dn     (up_dn),
         .load      (load),
         .load_val  (load_val[4*gi +: 4]),
         .value     (w_digit[gi]),
         .carry_out (w_carry)
      );
      assign count_bcd[4*gi +: 4] = w_digit[gi];
   end

   // A carry out of the top digit is exactly the all-9s/all-0s rollover.
   always_ff @(posedge clk) begin
      if (reset) r_wrap <= 1'b0;
      else       r_wrap <= g_dig[NUM_DIGITS-1].w_carry & ~load;
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic w_hi_zero;
   always_comb begin
      w_blank   = 1'b0;
      w_hi_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         w_hi_zero = w_hi_zero & (w_digit[i] == 4'd0);
         if (r_scan_idx == IDX_W'(i)) w_blank = w_hi_zero;
      end
   end
`else
   assign w_blank = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_scan_cnt  <= '0;
         r_scan_idx  <= '0;
         r_digit_sel <= NUM_DIGITS'(1);
         r_segments  <= SEG_0;
      end else begin
         if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            r_scan_idx <= (r_scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_scan_idx + 1'b1;
         end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
         end
         r_digit_sel <= NUM_DIGITS'(1) << r_scan_idx;
         r_segments  <= w_blank ? 7'd0 : seg7_decode(w_digit[r_scan_idx]);
      end
   end

   assign segments  = r_segments;
   assign digit_sel = r_digit_sel;
   assign tick      = r_tick;
   assign wrap      = r_wrap;

endmodule
